// File: rtl/game_timebase_pkg.sv
// Shared game constants: seconds-counter width and limits used by the timebase and game control.
package game_timebase_pkg;

    localparam int SEC_WIDTH = 6;

    typedef logic [SEC_WIDTH-1:0] sec_t;

    localparam sec_t SEC_MAX       = 6'd63;
    localparam sec_t COUNTDOWN_MAX = 6'd5;
    localparam sec_t GAME_TIME_MAX = 6'd30;

    // Seconds never roll over; they park at SEC_MAX.
    function automatic sec_t sec_sat_inc(input sec_t s);
        return (s == SEC_MAX) ? s : s + sec_t'(1);
    endfunction

endpackage

// File: rtl/game_timebase_sec_channel.sv
// One timebase channel: prescaler, saturating seconds counter and a one-cycle tick per increment.
module sec_channel
    import game_timebase_pkg::*;
#(
    parameter int TICKS_PER_SEC = 100_000_000,
    parameter int PRESC_W       = $clog2(TICKS_PER_SEC)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable,
    input  logic                 clear,
    output logic [SEC_WIDTH-1:0] seconds,
    output logic                 tick,
    output logic [PRESC_W-1:0]   prescaler_next
);

    localparam logic [PRESC_W-1:0] PRESC_TOP = PRESC_W'(TICKS_PER_SEC - 1);

    logic [PRESC_W-1:0] presc_reg;
    sec_t               sec_reg;
    sec_t               sec_next;
    logic               tick_reg;
    logic               tick_next;

    always_comb begin
        prescaler_next = presc_reg;
        sec_next       = sec_reg;
        tick_next      = 1'b0;
        if (clear) begin
            prescaler_next = '0;
            sec_next       = '0;
        end else if (enable) begin
            if (presc_reg == PRESC_TOP) begin
                prescaler_next = '0;
                sec_next       = sec_sat_inc(sec_reg);
                tick_next      = (sec_reg != SEC_MAX);
            end else begin
                prescaler_next = presc_reg + PRESC_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_reg <= '0;
            sec_reg   <= '0;
            tick_reg  <= 1'b0;
        end else begin
            presc_reg <= prescaler_next;
            sec_reg   <= sec_next;
            tick_reg  <= tick_next;
        end
    end

    assign seconds = sec_reg;
    assign tick    = tick_reg;

endmodule

// File: rtl/game_timebase.sv
// Game timebase: independent countdown and game-time second counters plus a half-second blink phase.
module game_timebase
    import game_timebase_pkg::*;
#(
    parameter int TICKS_PER_SEC = 100_000_000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable_countdown,
    input  logic                 clear_countdown,
    input  logic                 enable_game_timer,
    input  logic                 clear_game_timer,
    output logic [SEC_WIDTH-1:0] countdown_sec,
    output logic [SEC_WIDTH-1:0] game_time_sec,
    output logic                 countdown_tick,
    output logic                 game_tick,
    output logic                 game_half_phase
);

    localparam int                 PRESC_W   = $clog2(TICKS_PER_SEC);
    localparam logic [PRESC_W-1:0] HALF_MARK = PRESC_W'(TICKS_PER_SEC / 2);

    logic [PRESC_W-1:0] countdown_presc_unused;
    logic [PRESC_W-1:0] game_presc_next;
    logic               half_phase_reg;

    sec_channel #(
        .TICKS_PER_SEC (TICKS_PER_SEC),
        .PRESC_W       (PRESC_W)
    ) u_countdown (
        .clk            (clk),
        .rst_n          (rst_n),
        .enable         (enable_countdown),
        .clear          (clear_countdown),
        .seconds        (countdown_sec),
        .tick           (countdown_tick),
        .prescaler_next (countdown_presc_unused)
    );

    sec_channel #(
        .TICKS_PER_SEC (TICKS_PER_SEC),
        .PRESC_W       (PRESC_W)
    ) u_game (
        .clk            (clk),
        .rst_n          (rst_n),
        .enable         (enable_game_timer),
        .clear          (clear_game_timer),
        .seconds        (game_time_sec),
        .tick           (game_tick),
        .prescaler_next (game_presc_next)
    );

    // Decoded from the next prescaler value so the flag tracks the prescaler register exactly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            half_phase_reg <= 1'b0;
        end else begin
            half_phase_reg <= (game_presc_next >= HALF_MARK);
        end
    end

    assign game_half_phase = half_phase_reg;

endmodule

// File: doc/game_timebase.md
GAME_TIMEBASE -- requirements
Module: game_timebase

Interface
REQ-001 Parameter TICKS_PER_SEC, default 100_000_000: enabled clk cycles per counted second; legal range 2..2^27.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 enable_countdown  input  1  level; countdown channel counts while high.
REQ-005 clear_countdown  input  1  level; zeroes countdown channel.
REQ-006 enable_game_timer  input  1  level; game channel counts while high.
REQ-007 clear_game_timer  input  1  level; zeroes game channel.
REQ-008 countdown_sec  output  6  whole seconds counted by countdown channel since last clear.
REQ-009 game_time_sec  output  6  whole seconds counted by game channel since last clear.
REQ-010 countdown_tick  output  1  one-cycle pulse on each countdown_sec increment.
REQ-011 game_tick  output  1  one-cycle pulse on each game_time_sec increment.
REQ-012 game_half_phase  output  1  high while game channel prescaler >= TICKS_PER_SEC/2 (integer division); display blink.

Function
REQ-013 Two identical, fully independent channels (countdown, game); each holds a prescaler (0..TICKS_PER_SEC-1) and a 6-bit seconds counter.
REQ-014 All outputs registered; no combinational input-to-output path.
REQ-015 Per channel, per cycle, priority: clear > enable > hold.
REQ-016 Clear high: prescaler<=0, seconds<=0, tick<=0, regardless of enable.
REQ-017 Enable high, clear low, prescaler < TICKS_PER_SEC-1: prescaler increments; seconds held; tick<=0.
REQ-018 Enable high, clear low, prescaler == TICKS_PER_SEC-1: prescaler<=0; seconds increments and tick<=1 unless seconds == 63.
REQ-019 Saturation: seconds at 63 stays 63; no further tick; prescaler keeps wrapping.
REQ-020 Enable low, clear low: prescaler and seconds held (pause, sub-second phase preserved); tick<=0.
REQ-021 Latency: after a cycle with clear high, seconds output first reads 1 after exactly TICKS_PER_SEC enabled, uncleared cycles; tick asserts in the same cycle seconds changes.
REQ-022 Clear held for multiple cycles: channel stays at zero throughout; counting starts on first cycle with clear low and enable high.
REQ-023 Activity on one channel never alters the other channel's state.
REQ-024 game_half_phase reflects the game prescaler register; cleared to 0 by clear_game_timer.

Reset
REQ-025 rst_n low asynchronously forces both prescalers, countdown_sec, game_time_sec, countdown_tick, game_tick and game_half_phase to 0.
REQ-026 Reset mid-second discards partial progress; after rst_n release, the first increment requires a full TICKS_PER_SEC enabled cycles.

Structure
REQ-027 Shared game package holds COUNTDOWN_MAX (5), GAME_TIME_MAX (30), SEC_WIDTH (6) and SEC_MAX (63), consumed by both this block and the game control FSM.
REQ-028 One sub-module, sec_channel (prescaler + saturating seconds counter + tick), instantiated twice; top adds only game_half_phase decode.

Verification (TICKS_PER_SEC=4 in bench)
REQ-029 Assert rst_n low for 3 cycles -> all outputs 0 during and after release with enables low.
REQ-030 clear_countdown 1 cycle, then enable_countdown high for 20 cycles -> countdown_sec steps 1..5 every 4 cycles; 5 single-cycle countdown_tick pulses; game outputs stay 0.
REQ-031 enable_game_timer high 6 cycles (game_time_sec=1, prescaler=2), low 10 cycles, high 2 more -> game_time_sec stays 1 during pause, reads 2 after the 2nd resumed cycle; game_half_phase high while prescaler is 2 or 3.
REQ-032 clear_game_timer and enable_game_timer high together for 3 cycles at game_time_sec=7 -> game_time_sec=0, no tick; next 4 enabled cycles -> 1.
REQ-033 enable_countdown high 260 cycles from clear -> countdown_sec reaches 63 at cycle 252 with 63 ticks total; remains 63 with no tick through cycle 260.
REQ-034 rst_n pulsed low mid-second at game_time_sec=3 -> immediate zero; after release, 4 enabled cycles -> game_time_sec=1.
